// File: rtl/sensor_scan_mux.sv
// Eight-channel sensor scan multiplexer: grants one pending channel, holds its byte until downstream accepts.
// Define ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module sensor_scan_mux (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sensor_in0,
    input  logic [7:0] sensor_in1,
    input  logic [7:0] sensor_in2,
    input  logic [7:0] sensor_in3,
    input  logic [7:0] sensor_in4,
    input  logic [7:0] sensor_in5,
    input  logic [7:0] sensor_in6,
    input  logic [7:0] sensor_in7,
    input  logic [7:0] sensor_valid,
    output logic [7:0] sensor_ack,
    output logic [7:0] data_out,
    output logic [2:0] address_out,
    output logic       out_valid,
    input  logic       out_ready
);

    // state | meaning
    // IDLE  | no word held; captures a pending channel when any sensor_valid bit is set
    // SEND  | word held with out_valid=1; ack pulses in the first cycle only
    typedef enum logic {IDLE, SEND} state_t;

    state_t     state_q;
    logic [7:0] data_q;
    logic [2:0] addr_q;
    logic [7:0] ack_q;
    logic       valid_q;
    logic [2:0] grant_idx;
    logic [7:0] sensor_arr [8];

    assign sensor_arr[0] = sensor_in0;
    assign sensor_arr[1] = sensor_in1;
    assign sensor_arr[2] = sensor_in2;
    assign sensor_arr[3] = sensor_in3;
    assign sensor_arr[4] = sensor_in4;
    assign sensor_arr[5] = sensor_in5;
    assign sensor_arr[6] = sensor_in6;
    assign sensor_arr[7] = sensor_in7;

`ifdef ROUND_ROBIN_EN
    logic [2:0] ptr_q;

    // Scan downward so the last hit is the nearest set bit at or after the pointer.
    always_comb begin
        logic [2:0] idx;
        grant_idx = 3'd0;
        idx       = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr_q + 3'(k);
            if (sensor_valid[idx]) begin
                grant_idx = idx;
            end
        end
    end
`else
    always_comb begin
        grant_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (sensor_valid[k]) begin
                grant_idx = 3'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            addr_q  <= 3'd0;
            ack_q   <= 8'h00;
            valid_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= 3'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 8'h00;
                    if (sensor_valid != 8'h00) begin
                        state_q <= SEND;
                        data_q  <= sensor_arr[grant_idx];
                        addr_q  <= grant_idx;
                        ack_q   <= 8'h01 << grant_idx;
                        valid_q <= 1'b1;
                    end
                end
                SEND: begin
                    ack_q <= 8'h00;
                    if (out_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
                        ptr_q   <= addr_q + 3'd1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 8'h00;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sensor_ack  = ack_q;
    assign data_out    = data_q;
    assign address_out = addr_q;
    assign out_valid   = valid_q;

endmodule
